// File: rtl/hier_node_dispatch.sv
// Tree node: a one-entry request register dispatched round-robin to credited
// children, and child responses merged round-robin into one tagged stream.
// Handshake rule on every channel: a transfer occurs in a cycle where valid and
// ready are both high; once this node raises a valid, it holds it and its payload
// stable until the transfer completes.
module hier_node_dispatch #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 4,
  parameter int MAX_OUT   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [NUM_CHILD-1:0]        child_en,
  output logic [NUM_CHILD-1:0]        ch_valid,
  input  logic [NUM_CHILD-1:0]        ch_ready,
  output logic [DATA_W-1:0]           ch_data,
  input  logic [NUM_CHILD-1:0]        rsp_valid,
  output logic [NUM_CHILD-1:0]        rsp_ready,
  input  logic [NUM_CHILD*DATA_W-1:0] rsp_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_child,
  output logic                        busy,
  output logic                        err_unexp
);

  localparam logic [3:0] CRED_MAX = 4'(MAX_OUT);

  logic                 req_vld_q, req_vld_d;
  logic [DATA_W-1:0]    req_data_q, req_data_d;
  logic                 lock_q, lock_d;
  logic [NUM_CHILD-1:0] lock_oh_q, lock_oh_d;
  logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]     req_ptr_q, req_ptr_d;
  logic [IDX_W-1:0]     rsp_ptr_q, rsp_ptr_d;
  logic [3:0]           cred_q [NUM_CHILD];
  logic [3:0]           cred_d [NUM_CHILD];
  logic                 out_vld_q, out_vld_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0]     out_child_q, out_child_d;
  logic                 err_q, err_d;

  logic [NUM_CHILD-1:0] elig, full, sel_oh, gnt_oh, ch_fire_vec;
  logic                 sel_found, gnt_found, ch_fire, rsp_fire, out_free;
  int                   sel_int, gnt_int;

  function automatic int wrap(input int v);
    return (v >= NUM_CHILD) ? v - NUM_CHILD : v;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CHILD; i++) begin
      full[i] = (cred_q[i] == CRED_MAX);
      elig[i] = child_en[i] && (cred_q[i] != 4'd0);
    end
  end

  // Descending scan so the last hit is the first eligible child at/after the pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_oh    = '0;
    sel_int   = 0;
    if (lock_q) begin
      sel_found = 1'b1;
      sel_oh    = lock_oh_q;
      sel_int   = int'(lock_idx_q);
    end else begin
      for (int off = NUM_CHILD - 1; off >= 0; off--) begin
        if (elig[wrap(int'(req_ptr_q) + off)]) begin
          sel_found = 1'b1;
          sel_oh    = '0;
          sel_oh[wrap(int'(req_ptr_q) + off)] = 1'b1;
          sel_int   = wrap(int'(req_ptr_q) + off);
        end
      end
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_oh    = '0;
    gnt_int   = 0;
    for (int off = NUM_CHILD - 1; off >= 0; off--) begin
      if (rsp_valid[wrap(int'(rsp_ptr_q) + off)]) begin
        gnt_found = 1'b1;
        gnt_oh    = '0;
        gnt_oh[wrap(int'(rsp_ptr_q) + off)] = 1'b1;
        gnt_int   = wrap(int'(rsp_ptr_q) + off);
      end
    end
  end

  // Handshake outputs are forced low while rst is high so nothing transfers then.
  assign ch_valid    = (!rst && req_vld_q && sel_found) ? sel_oh : '0;
  assign ch_data     = req_data_q;
  assign ch_fire_vec = ch_valid & ch_ready;
  assign ch_fire     = |ch_fire_vec;
  assign in_ready    = !rst && (child_en != '0) && (!req_vld_q || ch_fire);

  assign out_free  = !out_vld_q || out_ready;
  assign rsp_ready = (!rst && gnt_found && out_free) ? gnt_oh : '0;
  assign rsp_fire  = |rsp_ready;

  assign out_valid = out_vld_q && !rst;
  assign out_data  = out_data_q;
  assign out_child = out_child_q;
  assign err_unexp = err_q;
  assign busy      = req_vld_q | out_vld_q | (|(~full));

  always_comb begin
    req_vld_d  = req_vld_q;
    req_data_d = req_data_q;
    lock_d     = lock_q;
    lock_oh_d  = lock_oh_q;
    lock_idx_d = lock_idx_q;
    req_ptr_d  = req_ptr_q;
    if (ch_fire) begin
      req_vld_d = 1'b0;
      lock_d    = 1'b0;
      req_ptr_d = IDX_W'(wrap(sel_int + 1));
    end else if (req_vld_q && sel_found) begin
      lock_d     = 1'b1;
      lock_oh_d  = sel_oh;
      lock_idx_d = IDX_W'(sel_int);
    end
    if (in_valid && in_ready) begin
      req_vld_d  = 1'b1;
      req_data_d = in_data;
    end
  end

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_child_d = out_child_q;
    rsp_ptr_d   = rsp_ptr_q;
    if (rsp_fire) begin
      out_vld_d   = 1'b1;
      out_data_d  = rsp_data[gnt_int*DATA_W +: DATA_W];
      out_child_d = IDX_W'(gnt_int);
      rsp_ptr_d   = IDX_W'(wrap(gnt_int + 1));
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  // A response on a child with nothing outstanding flags an error and leaves its credit alone.
  always_comb begin
    err_d = err_q | (|(rsp_ready & full));
    for (int i = 0; i < NUM_CHILD; i++) begin
      cred_d[i] = cred_q[i];
      if (ch_fire_vec[i] && !rsp_ready[i]) begin
        cred_d[i] = cred_q[i] - 4'd1;
      end else if (rsp_ready[i] && !ch_fire_vec[i] && !full[i]) begin
        cred_d[i] = cred_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld_q   <= 1'b0;
      req_data_q  <= '0;
      lock_q      <= 1'b0;
      lock_oh_q   <= '0;
      lock_idx_q  <= '0;
      req_ptr_q   <= '0;
      rsp_ptr_q   <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_child_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_CHILD; i++) cred_q[i] <= CRED_MAX;
    end else begin
      req_vld_q   <= req_vld_d;
      req_data_q  <= req_data_d;
      lock_q      <= lock_d;
      lock_oh_q   <= lock_oh_d;
      lock_idx_q  <= lock_idx_d;
      req_ptr_q   <= req_ptr_d;
      rsp_ptr_q   <= rsp_ptr_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_child_q <= out_child_d;
      err_q       <= err_d;
      for (int i = 0; i < NUM_CHILD; i++) cred_q[i] <= cred_d[i];
    end
  end

endmodule

// File: tb/tb_hier_node_dispatch.sv
// Bench for hier_node_dispatch: vector table, directed corner sequences and a
// randomized phase checked against a transaction-level reference model.
module tb_hier_node_dispatch;
  localparam int NC = 5;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int MO = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [DW-1:0]    in_data;
  logic [NC-1:0]    child_en, ch_valid, ch_ready;
  logic [DW-1:0]    ch_data;
  logic [NC-1:0]    rsp_valid, rsp_ready;
  logic [NC*DW-1:0] rsp_data;
  logic             out_valid, out_ready;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_child;
  logic             busy, err_unexp;

  hier_node_dispatch #(.NUM_CHILD(NC), .DATA_W(DW), .IDX_W(IW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .child_en(child_en),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_child(out_child),
    .busy(busy), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; child_en = '1;
    ch_ready = '0; rsp_valid = '0; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_rsp_table_data();
    for (int i = 0; i < NC; i++) rsp_data[i*DW +: DW] = DW'(16'hC000 + i);
  endtask

  typedef struct {
    logic          in_v;
    logic [DW-1:0] in_d;
    logic [NC-1:0] rv;
    logic          outr;
    logic          e_inr;
    logic [NC-1:0] e_chv;
    logic [DW-1:0] e_chd;
    logic [NC-1:0] e_rr;
    logic          e_ov;
    logic [IW-1:0] e_oc;
    logic          e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input logic [DW-1:0] id, input logic [NC-1:0] rv,
                     input logic outr, input logic inr, input logic [NC-1:0] chv,
                     input logic [DW-1:0] chd, input logic [NC-1:0] rr, input logic ov,
                     input logic [IW-1:0] oc, input logic bz);
    vec_t v;
    v.in_v = iv; v.in_d = id; v.rv = rv; v.outr = outr; v.e_inr = inr; v.e_chv = chv;
    v.e_chd = chd; v.e_rr = rr; v.e_ov = ov; v.e_oc = oc; v.e_busy = bz;
    tbl.push_back(v);
  endtask

  // Reference model state for the randomized phase
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_dq[$];
  int            out_cq[$];
  int            m_cred[NC];
  int            m_lock, m_rptr, m_sptr;
  logic          m_err;

  initial begin
    do_reset();
    rsp_data = '0;

    // Reset state, then in_ready's dependence on child_en
    child_en = '0;
    @(negedge clk);
    check("rst_in_ready_en0", in_ready, 0);
    child_en = '1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_ch_valid", ch_valid, 0);
    check("rst_rsp_ready", rsp_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_unexp, 0);
    next_cycle();

    // Round-robin dispatch, credit exhaustion and response merge (all ch_ready high)
    add(1, 16'h1000, 5'b00000, 1, 1, 5'b00000, 16'h0000, 5'b00000, 0, 0, 0);
    add(1, 16'h1001, 5'b00000, 1, 1, 5'b00001, 16'h1000, 5'b00000, 0, 0, 1);
    add(1, 16'h1002, 5'b00000, 1, 1, 5'b00010, 16'h1001, 5'b00000, 0, 0, 1);
    add(1, 16'h1003, 5'b00000, 1, 1, 5'b00100, 16'h1002, 5'b00000, 0, 0, 1);
    add(1, 16'h1004, 5'b00000, 1, 1, 5'b01000, 16'h1003, 5'b00000, 0, 0, 1);
    add(1, 16'h1005, 5'b00000, 1, 1, 5'b10000, 16'h1004, 5'b00000, 0, 0, 1);
    add(1, 16'h1006, 5'b00000, 1, 1, 5'b00001, 16'h1005, 5'b00000, 0, 0, 1);
    add(1, 16'h1007, 5'b00000, 1, 1, 5'b00010, 16'h1006, 5'b00000, 0, 0, 1);
    add(1, 16'h1008, 5'b00000, 1, 1, 5'b00100, 16'h1007, 5'b00000, 0, 0, 1);
    add(1, 16'h1009, 5'b00000, 1, 1, 5'b01000, 16'h1008, 5'b00000, 0, 0, 1);
    add(0, 16'h0000, 5'b00000, 1, 1, 5'b10000, 16'h1009, 5'b00000, 0, 0, 1);
    add(0, 16'h0000, 5'b00000, 1, 1, 5'b00000, 16'h0000, 5'b00000, 0, 0, 1);
    add(1, 16'h100A, 5'b00000, 1, 1, 5'b00000, 16'h0000, 5'b00000, 0, 0, 1);
    add(0, 16'h0000, 5'b00000, 1, 0, 5'b00000, 16'h0000, 5'b00000, 0, 0, 1);
    add(0, 16'h0000, 5'b10011, 1, 0, 5'b00000, 16'h0000, 5'b00001, 0, 0, 1);
    add(0, 16'h0000, 5'b10011, 1, 1, 5'b00001, 16'h100A, 5'b00010, 1, 0, 1);
    add(0, 16'h0000, 5'b10011, 1, 1, 5'b00000, 16'h0000, 5'b10000, 1, 1, 1);
    add(0, 16'h0000, 5'b10011, 1, 1, 5'b00000, 16'h0000, 5'b00001, 1, 4, 1);
    add(0, 16'h0000, 5'b10011, 1, 1, 5'b00000, 16'h0000, 5'b00010, 1, 0, 1);
    add(0, 16'h0000, 5'b10011, 0, 1, 5'b00000, 16'h0000, 5'b00000, 1, 1, 1);
    add(0, 16'h0000, 5'b10011, 0, 1, 5'b00000, 16'h0000, 5'b00000, 1, 1, 1);
    add(0, 16'h0000, 5'b00000, 1, 1, 5'b00000, 16'h0000, 5'b00000, 1, 1, 1);
    add(0, 16'h0000, 5'b00000, 1, 1, 5'b00000, 16'h0000, 5'b00000, 0, 0, 1);

    set_rsp_table_data();
    child_en = '1;
    ch_ready = '1;
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].in_v;
      in_data   = tbl[i].in_d;
      rsp_valid = tbl[i].rv;
      out_ready = tbl[i].outr;
      @(negedge clk);
      check($sformatf("t%0d_in_ready", i), in_ready, tbl[i].e_inr);
      check($sformatf("t%0d_ch_valid", i), ch_valid, tbl[i].e_chv);
      if (tbl[i].e_chv != '0) check($sformatf("t%0d_ch_data", i), ch_data, tbl[i].e_chd);
      check($sformatf("t%0d_rsp_ready", i), rsp_ready, tbl[i].e_rr);
      check($sformatf("t%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check($sformatf("t%0d_out_child", i), out_child, tbl[i].e_oc);
        check($sformatf("t%0d_out_data", i), out_data, DW'(16'hC000 + tbl[i].e_oc));
      end
      check($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("t%0d_err", i), err_unexp, 0);
      next_cycle();
    end

    // Lock holds on child 1 while its enable drops and it stalls
    do_reset();
    ch_ready = '1;
    in_valid = 1; in_data = 16'hF000;
    next_cycle();
    in_data = 16'hF001;
    @(negedge clk);
    check("lk_first_ch_valid", ch_valid, 5'b00001);
    next_cycle();
    in_valid = 0; ch_ready = '0;
    @(negedge clk);
    check("lk_ch_valid", ch_valid, 5'b00010);
    check("lk_ch_data", ch_data, 16'hF001);
    next_cycle();
    child_en = 5'b11101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("lk%0d_ch_valid", k), ch_valid, 5'b00010);
      check($sformatf("lk%0d_ch_data", k), ch_data, 16'hF001);
      check($sformatf("lk%0d_in_ready", k), in_ready, 0);
      next_cycle();
    end
    ch_ready = 5'b00010;
    @(negedge clk);
    check("lk_fire_ch_valid", ch_valid, 5'b00010);
    check("lk_fire_in_ready", in_ready, 1);
    next_cycle();
    @(negedge clk);
    check("lk_after_ch_valid", ch_valid, 0);
    check("lk_after_busy", busy, 1);
    next_cycle();

    // Credit exhaustion on a single enabled child, freed by one response
    do_reset();
    child_en = 5'b00100; ch_ready = '1; out_ready = 1;
    in_valid = 1; in_data = 16'hE000;
    next_cycle();
    in_data = 16'hE001;
    @(negedge clk);
    check("cx_d0_ch_valid", ch_valid, 5'b00100);
    check("cx_d0_ch_data", ch_data, 16'hE000);
    next_cycle();
    in_data = 16'hE002;
    @(negedge clk);
    check("cx_d1_ch_valid", ch_valid, 5'b00100);
    check("cx_d1_ch_data", ch_data, 16'hE001);
    next_cycle();
    in_valid = 0;
    @(negedge clk);
    check("cx_held_ch_valid", ch_valid, 0);
    check("cx_held_in_ready", in_ready, 0);
    next_cycle();
    rsp_valid = 5'b00100;
    @(negedge clk);
    check("cx_rsp_ready", rsp_ready, 5'b00100);
    check("cx_rsp_ch_valid", ch_valid, 0);
    next_cycle();
    rsp_valid = '0;
    @(negedge clk);
    check("cx_freed_ch_valid", ch_valid, 5'b00100);
    check("cx_freed_ch_data", ch_data, 16'hE002);
    next_cycle();
    @(negedge clk);
    check("cx_done_ch_valid", ch_valid, 0);
    next_cycle();

    // Unexpected response from child 3
    do_reset();
    rsp_data[3*DW +: DW] = 16'hBEEF;
    rsp_valid = 5'b01000; out_ready = 1;
    @(negedge clk);
    check("ux_rsp_ready", rsp_ready, 5'b01000);
    check("ux_err_before", err_unexp, 0);
    next_cycle();
    rsp_valid = '0;
    @(negedge clk);
    check("ux_out_valid", out_valid, 1);
    check("ux_out_child", out_child, 3);
    check("ux_out_data", out_data, 16'hBEEF);
    check("ux_err", err_unexp, 1);
    next_cycle();
    @(negedge clk);
    check("ux_drained", out_valid, 0);
    check("ux_busy_credit_full", busy, 0);
    check("ux_err_sticky", err_unexp, 1);
    next_cycle();
    @(negedge clk);
    check("ux_err_sticky2", err_unexp, 1);
    next_cycle();

    // Reset with a request held, a response held and three requests outstanding
    do_reset();
    ch_ready = '1; out_ready = 0; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      in_data = DW'(16'hD000 + k);
      next_cycle();
    end
    in_valid = 0; ch_ready = '0; rsp_valid = 5'b10000;
    @(negedge clk);
    check("mr_busy_pre", busy, 1);
    next_cycle();
    rsp_valid = '0;
    @(negedge clk);
    check("mr_out_valid_pre", out_valid, 1);
    check("mr_ch_valid_pre", ch_valid, 5'b01000);
    rst = 1; in_valid = 1; in_data = 16'hD0FF;
    next_cycle();
    rst = 0; in_valid = 0;
    @(negedge clk);
    check("mr_ch_valid", ch_valid, 0);
    check("mr_out_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_err", err_unexp, 0);
    next_cycle();

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < NC; i++) m_cred[i] = MO;
    m_lock = -1; m_rptr = 0; m_sptr = 0; m_err = 1'b0;
    exp_q.delete(); out_dq.delete(); out_cq.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int pick, g;
      logic dfire, rfire, e_inr, free, e_busy;
      logic [NC-1:0] e_chv, e_rr;
      if ($urandom_range(0, 15) == 0) child_en = NC'($urandom_range(0, (1 << NC) - 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      ch_ready  = NC'($urandom);
      rsp_valid = NC'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NC; i++) rsp_data[i*DW +: DW] = DW'($urandom);
      @(negedge clk);

      pick = -1;
      if (exp_q.size() > 0) begin
        if (m_lock >= 0) pick = m_lock;
        else
          for (int o = 0; o < NC; o++) begin
            int c;
            c = (m_rptr + o) % NC;
            if (pick < 0 && child_en[c] && m_cred[c] > 0) pick = c;
          end
      end
      e_chv = '0;
      if (pick >= 0) e_chv[pick] = 1'b1;
      dfire = (pick >= 0) && ch_ready[pick];
      e_inr = (child_en != '0) && (exp_q.size() == 0 || dfire);
      g = -1;
      for (int o = 0; o < NC; o++) begin
        int c;
        c = (m_sptr + o) % NC;
        if (g < 0 && rsp_valid[c]) g = c;
      end
      free  = (out_dq.size() == 0) || out_ready;
      rfire = (g >= 0) && free;
      e_rr  = '0;
      if (rfire) e_rr[g] = 1'b1;
      e_busy = (exp_q.size() > 0) || (out_dq.size() > 0);
      for (int i = 0; i < NC; i++) if (m_cred[i] != MO) e_busy = 1'b1;

      check("r_in_ready", in_ready, e_inr);
      check("r_ch_valid", ch_valid, e_chv);
      if (pick >= 0) check("r_ch_data", ch_data, exp_q[0]);
      check("r_rsp_ready", rsp_ready, e_rr);
      check("r_out_valid", out_valid, out_dq.size() > 0);
      if (out_dq.size() > 0) begin
        check("r_out_data", out_data, out_dq[0]);
        check("r_out_child", out_child, out_cq[0]);
      end
      check("r_busy", busy, e_busy);
      check("r_err", err_unexp, m_err);

      for (int i = 0; i < NC; i++) begin
        logic dsp, rsp;
        dsp = dfire && (pick == i);
        rsp = rfire && (g == i);
        if (rsp && m_cred[i] == MO) m_err = 1'b1;
        if (dsp && !rsp) m_cred[i]--;
        else if (rsp && !dsp && m_cred[i] < MO) m_cred[i]++;
      end
      if (dfire) begin
        void'(exp_q.pop_front());
        m_rptr = (pick + 1) % NC;
        m_lock = -1;
      end else if (pick >= 0) begin
        m_lock = pick;
      end
      if (in_valid && e_inr) exp_q.push_back(in_data);
      if (out_ready && out_dq.size() > 0) begin
        void'(out_dq.pop_front());
        void'(out_cq.pop_front());
      end
      if (rfire) begin
        out_dq.push_back(rsp_data[g*DW +: DW]);
        out_cq.push_back(g);
        m_sptr = (g + 1) % NC;
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
